rom_dma_engine: RTL and testbench
=================================

Name: rom_dma_engine

Overview:
- Bulk-copies 16-bit words from StrataFlash, via romController's addr/load/data/ready handshake, into the processor's memory bus (memaddr/memwrite/writedata).
- Sits between romController (upstream) and memory_controller (downstream).
- Stalls the processor through proc_en while a transfer runs.
- Programmed by processor writes decoded by memory_controller (en + wr_mode).

Parameters:
- SRC_STEP, 2: flash address increment per word (byte-addressed flash, 16-bit mode).
- TIMEOUT, 1023: max cycles waiting for ready before abort; counter width is clog2(TIMEOUT+1).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-low reset; system connects rst_btn directly.
- en  input  1  register select from memory_controller.
- write  input  1  processor memwrite.
- wr_mode  input  2  register index: 0 src_lo, 1 src_hi, 2 dst, 3 len+start.
- ctrl_data  input  16  processor writedata.
- src_addr  output  24  flash address to romController.
- load_rom  output  1  one-cycle read request to romController.
- src_data  input  16  flash word from romController.
- ready  input  1  romController data-valid level.
- dst_addr  output  16  memory bus address during transfer.
- dst_write  output  1  memory write strobe.
- dst_data  output  16  memory write data.
- proc_en  output  1  processor enable; low while busy.
- status  output  16  bit15 busy, bit14 error, bits13:0 = 0.

Behaviour:
- Reset values: src_addr=0, dst_addr=0, len=0, load_rom=0, dst_write=0, dst_data=0, proc_en=1, status=0, state IDLE.
- Register writes are accepted only when en && write && state==IDLE; ignored otherwise.
  - mode 0: src_addr[15:0] = ctrl_data.
  - mode 1: src_addr[23:16] = ctrl_data[7:0].
  - mode 2: dst_addr = ctrl_data.
  - mode 3: len = ctrl_data, clear error, start.
- Start with len==0: stays IDLE; proc_en never drops; no load_rom; error cleared.
- FSM states:
  - IDLE: proc_en=1. On a nonzero start, go to REQ next cycle and drop proc_en the same edge.
  - REQ: load_rom=1 for exactly one cycle with the current src_addr. Clear the timeout counter. Go to WAIT.
  - WAIT: ready is ignored on the first WAIT cycle, since it may still be high from the previous word. From the second cycle on, ready==1 latches src_data into dst_data and goes to WRITE. The timeout counter increments each WAIT cycle. If the counter reaches TIMEOUT: set error, return to IDLE with proc_en=1, no write, and leave src_addr, dst_addr and len at their current values.
  - WRITE: dst_write=1 for one cycle with the current dst_addr and dst_data. Next edge: dst_addr+=1 (wraps 16-bit), src_addr+=SRC_STEP (wraps 24-bit), len-=1. If the new len==0, go to IDLE and raise proc_en; else go to REQ.
- Per-word cost is 1 (REQ) + W (WAIT, W>=2) + 1 (WRITE) cycles. Words are never pipelined.
- status[15] = (state!=IDLE); status[14] = error (sticky until the next mode-3 write or reset).
- dst_write and load_rom are never high in the same cycle. dst_write is only high in WRITE.
- Reset mid-transfer: all state returns to reset values asynchronously and proc_en rises immediately.
- A ready pulse that arrives outside WAIT is ignored.

Decomposition:
- Shared package: the wr_mode encodings (DMA_SRC_LO=0, DMA_SRC_HI=1, DMA_DST=2, DMA_LEN_GO=3), the FSM state encoding, and the status bit positions.
- Sub-module dma_timeout_counter: clear/increment/expired; the only natural split.
- memory_controller owns the en decode and the mux selecting dma_* versus proc_* onto the bus when proc_en is low.

Test Plan:
- Write src_lo=0x0100, src_hi=0x12, dst=0x0200, len=3; ROM model returns 0xA000+n with ready 4 cycles after load. Required: three load_rom pulses at src 0x120100/0x120102/0x120104; writes of 0xA000/0xA001/0xA002 to 0x0200/0x0201/0x0202; proc_en low from the cycle after the start write until the cycle after the last WRITE; status ends 0x0000.
- len=0 start -> no load_rom; proc_en stays 1; status=0x0000.
- dst=0xFFFF, src=0xFFFFFE, len=2 -> writes to 0xFFFF then 0x0000; src_addr 0xFFFFFE then 0x000000.
- ready held high continuously from before the start -> the first WAIT cycle ignores it; data is captured on the second WAIT cycle; exactly len dst_write pulses.
- ROM never asserts ready -> after TIMEOUT WAIT cycles state is IDLE, status=0x4000, proc_en=1, no dst_write; a following mode-3 write clears status[14].
- rst low mid-WAIT of a 5-word transfer -> outputs at reset values immediately; after release, a register write in IDLE is accepted.

Source files
------------

// File: rtl/rom_dma_engine_pkg.sv
// Shared encodings for the ROM-to-memory DMA engine: register map, FSM states, status layout.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package rom_dma_engine_pkg;

  // Register index carried on wr_mode during a programming write
  localparam logic [1:0] DMA_SRC_LO = 2'd0;
  localparam logic [1:0] DMA_SRC_HI = 2'd1;
  localparam logic [1:0] DMA_DST    = 2'd2;
  localparam logic [1:0] DMA_LEN_GO = 2'd3;

  // Transfer sequencer states; one word is REQ -> WAIT (>=2 cycles) -> WRITE
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } dma_state_t;

  // Status word bit positions; remaining bits read as zero
  localparam int STAT_BUSY_BIT = 15;
  localparam int STAT_ERR_BIT  = 14;

  // Pack the busy/error flags into the processor-visible status word
  function automatic logic [15:0] make_status(input logic busy, input logic err);
    logic [15:0] s;
    s = 16'h0000;
    s[STAT_BUSY_BIT] = busy;
    s[STAT_ERR_BIT]  = err;
    return s;
  endfunction

endpackage

// File: rtl/rom_dma_engine_timeout_counter.sv
// Counts WAIT cycles for one flash word; flags the first WAIT cycle and the cycle that reaches the limit.
// Latency: count updates one cycle after i_inc; o_first/o_expired are combinational from the count.
// Backpressure: none; i_clr wins over i_inc, count saturates at TIMEOUT.
module dma_timeout_counter #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_first,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT      = CW'(TIMEOUT);
  localparam logic [CW-1:0] LIMIT_M1   = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  // Cycle counter: cleared per word request, advanced once per WAIT cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Zero count means this is the first WAIT cycle after the request
  assign o_first   = (r_count == '0);
  // This increment is the one that brings the count up to the limit
  assign o_expired = i_inc && (r_count == LIMIT_M1);

endmodule

// File: rtl/rom_dma_engine.sv
// Copies len 16-bit flash words via the romController handshake into the memory bus, stalling the CPU.
// Latency: start -> REQ next cycle; each word costs 1 REQ + W WAIT (W>=2) + 1 WRITE cycles, no overlap.
// Backpressure: waits on the ready level (first WAIT cycle ignored); aborts with error after TIMEOUT WAIT cycles.
module rom_dma_engine
  import rom_dma_engine_pkg::*;
#(
  parameter int SRC_STEP = 2,
  parameter int TIMEOUT  = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        write,
  input  logic [1:0]  wr_mode,
  input  logic [15:0] ctrl_data,
  output logic [23:0] src_addr,
  output logic        load_rom,
  input  logic [15:0] src_data,
  input  logic        ready,
  output logic [15:0] dst_addr,
  output logic        dst_write,
  output logic [15:0] dst_data,
  output logic        proc_en,
  output logic [15:0] status
);

  dma_state_t  r_state;
  logic [23:0] r_src_addr;
  logic [15:0] r_dst_addr;
  logic [15:0] r_len;
  logic        r_load_rom;
  logic        r_dst_write;
  logic [15:0] r_dst_data;
  logic        r_proc_en;
  logic        r_error;

  logic        w_wr_acc;
  logic        w_cnt_clr;
  logic        w_cnt_inc;
  logic        w_first;
  logic        w_expired;
  logic [23:0] w_src_next;

  // Programming writes only land while the engine is idle
  assign w_wr_acc   = en && write && (r_state == ST_IDLE);
  assign w_cnt_clr  = (r_state == ST_REQ);
  assign w_cnt_inc  = (r_state == ST_WAIT);
  assign w_src_next = r_src_addr + 24'(SRC_STEP);

  dma_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_cnt_clr),
    .i_inc     (w_cnt_inc),
    .o_first   (w_first),
    .o_expired (w_expired)
  );

  // Transfer sequencer with register file and registered strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_src_addr  <= 24'h000000;
      r_dst_addr  <= 16'h0000;
      r_len       <= 16'h0000;
      r_load_rom  <= 1'b0;
      r_dst_write <= 1'b0;
      r_dst_data  <= 16'h0000;
      r_proc_en   <= 1'b1;
      r_error     <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them below
      r_load_rom  <= 1'b0;
      r_dst_write <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_wr_acc) begin
            case (wr_mode)
              DMA_SRC_LO: r_src_addr[15:0]  <= ctrl_data;
              DMA_SRC_HI: r_src_addr[23:16] <= ctrl_data[7:0];
              DMA_DST:    r_dst_addr        <= ctrl_data;
              DMA_LEN_GO: begin
                r_len   <= ctrl_data;
                r_error <= 1'b0;
                // A zero-length start only clears the error flag
                if (ctrl_data != 16'h0000) begin
                  r_state    <= ST_REQ;
                  r_load_rom <= 1'b1;
                  r_proc_en  <= 1'b0;
                end
              end
            endcase
          end
        end
        ST_REQ: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          // ready may still be high from the previous word on the first WAIT cycle
          if (ready && !w_first) begin
            r_dst_data  <= src_data;
            r_dst_write <= 1'b1;
            r_state     <= ST_WRITE;
          end else if (w_expired) begin
            // Abort leaves addresses and remaining length where they stopped
            r_error   <= 1'b1;
            r_proc_en <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          r_dst_addr <= r_dst_addr + 16'd1;
          r_src_addr <= w_src_next;
          r_len      <= r_len - 16'd1;
          if (r_len == 16'd1) begin
            r_proc_en <= 1'b1;
            r_state   <= ST_IDLE;
          end else begin
            r_load_rom <= 1'b1;
            r_state    <= ST_REQ;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign src_addr  = r_src_addr;
  assign load_rom  = r_load_rom;
  assign dst_addr  = r_dst_addr;
  assign dst_write = r_dst_write;
  assign dst_data  = r_dst_data;
  assign proc_en   = r_proc_en;
  assign status    = make_status(r_state != ST_IDLE, r_error);

endmodule

// File: tb/tb_rom_dma_engine.sv
// Randomised scoreboard bench for rom_dma_engine with a behavioural flash model.
// Latency: expected loads/writes queued at stimulus time, popped by an independent monitor.
// Backpressure: flash model drives ready after a random or fixed delay, holds it, or never asserts it.
`timescale 1ns/1ps
module tb_rom_dma_engine;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        write = 1'b0;
  logic [1:0]  wr_mode = 2'd0;
  logic [15:0] ctrl_data = 16'h0000;
  logic [23:0] src_addr;
  logic        load_rom;
  logic [15:0] src_data = 16'h0000;
  logic        ready = 1'b0;
  logic [15:0] dst_addr;
  logic        dst_write;
  logic [15:0] dst_data;
  logic        proc_en;
  logic [15:0] status;

  always #5 clk = ~clk;

  rom_dma_engine #(.SRC_STEP(2), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .write     (write),
    .wr_mode   (wr_mode),
    .ctrl_data (ctrl_data),
    .src_addr  (src_addr),
    .load_rom  (load_rom),
    .src_data  (src_data),
    .ready     (ready),
    .dst_addr  (dst_addr),
    .dst_write (dst_write),
    .dst_data  (dst_data),
    .proc_en   (proc_en),
    .status    (status)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_load_cyc = 0;
  int last_wr_cyc = 0;
  int n_wr_seen = 0;
  bit sb_en = 1'b1;

  logic [23:0] exp_load_q[$];
  logic [31:0] exp_wr_q[$];
  int          gap_q[$];

  // flash model: 0 = ready after delay, 1 = ready held high, 2 = never ready
  int          rom_mode = 0;
  int          rom_delay_fixed = 0;
  logic [15:0] rom_base = 16'h0000;
  logic [23:0] rom_src0 = 24'h000000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got 0x%0h, required no event (t=%0t)", name, act, $time);
  endtask

  // Word n of the current image sits at rom_src0 + 2n and reads as rom_base + n
  function automatic logic [15:0] rom_word(input logic [23:0] a);
    logic [23:0] off;
    off = a - rom_src0;
    return rom_base + 16'(off >> 1);
  endfunction

  // Flash controller model reacting to load_rom
  initial begin : rom_proc
    logic [23:0] a;
    int d;
    forever begin
      @(negedge clk);
      if (rst && load_rom) begin
        a = src_addr;
        if (rom_mode == 1) begin
          src_data = rom_word(a);
          gap_q.push_back(3);
        end else if (rom_mode == 0) begin
          d = (rom_delay_fixed != 0) ? rom_delay_fixed : int'($urandom_range(1, 6));
          ready = 1'b0;
          gap_q.push_back(((d > 2) ? d : 2) + 1);
          repeat (d) @(negedge clk);
          src_data = rom_word(a);
          ready = 1'b1;
        end
      end
    end
  end

  // Monitor: pops expected events whenever the DUT strobes
  initial begin : monitor
    int g;
    forever begin
      @(negedge clk);
      if (rst && sb_en && (load_rom || dst_write)) begin
        check("pulse_overlap", {31'd0, load_rom & dst_write}, 32'd0);
        check("busy_during_pulse", {15'd0, proc_en, status}, 32'h0000_8000);
        if (load_rom) begin
          if (exp_load_q.size() == 0) fail("unexpected_load", {8'd0, src_addr});
          else check("load_addr", {8'd0, src_addr}, {8'd0, exp_load_q.pop_front()});
          last_load_cyc = cyc;
        end
        if (dst_write) begin
          if (exp_wr_q.size() == 0) fail("unexpected_write", {dst_addr, dst_data});
          else check("write_addr_data", {dst_addr, dst_data}, exp_wr_q.pop_front());
          if (gap_q.size() != 0) begin
            g = gap_q.pop_front();
            check("load_to_write_gap", cyc - last_load_cyc, g);
          end
          n_wr_seen++;
          last_wr_cyc = cyc;
        end
      end
    end
  end

  task automatic reg_write(input logic [1:0] m, input logic [15:0] d);
    @(negedge clk);
    en = 1'b1; write = 1'b1; wr_mode = m; ctrl_data = d;
    @(negedge clk);
    en = 1'b0; write = 1'b0; wr_mode = 2'($urandom); ctrl_data = 16'($urandom);
  endtask

  task automatic program_regs(input logic [23:0] src, input logic [15:0] dst);
    reg_write(2'd0, src[15:0]);
    reg_write(2'd1, {8'($urandom), src[23:16]});
    check("src_prog", {8'd0, src_addr}, {8'd0, src});
    reg_write(2'd2, dst);
    check("dst_prog", {16'd0, dst_addr}, {16'd0, dst});
  endtask

  task automatic do_xfer(input logic [23:0] src, input logic [15:0] dst, input logic [15:0] len,
                         input logic [15:0] base, input bit poke);
    bit got;
    rom_base = base;
    rom_src0 = src;
    for (int i = 0; i < int'(len); i++) begin
      exp_load_q.push_back(24'(src + 24'(2 * i)));
      exp_wr_q.push_back({16'(dst + 16'(i)), 16'(base + 16'(i))});
    end
    n_wr_seen = 0;
    program_regs(src, dst);
    reg_write(2'd3, len);
    if (len == 16'd0) begin
      for (int k = 0; k < 4; k++) begin
        check("len0_proc_en", {31'd0, proc_en}, 32'd1);
        @(negedge clk);
      end
      check("len0_status", {16'd0, status}, 32'h0);
      check("len0_no_load", n_wr_seen, 0);
    end else begin
      check("start_proc_en", {31'd0, proc_en}, 32'd0);
      check("start_load", {31'd0, load_rom}, 32'd1);
      if (poke) begin
        repeat (2) @(negedge clk);
        reg_write(2'd2, ~dst);
        reg_write(2'd0, ~src[15:0]);
      end
      got = 1'b0;
      for (int k = 0; k < int'(len) * 12 + 40 && !got; k++) begin
        @(negedge clk);
        if (proc_en) got = 1'b1;
      end
      if (!got) begin
        fail("xfer_timeout", {16'd0, status});
      end else begin
        check("proc_en_rise", cyc - last_wr_cyc, 1);
        check("n_writes", n_wr_seen, int'(len));
        check("status_end", {16'd0, status}, 32'h0);
        check("src_end", {8'd0, src_addr}, {8'd0, 24'(src + 24'(2 * int'(len)))});
        check("dst_end", {16'd0, dst_addr}, {16'd0, 16'(dst + len)});
        check("dst_data_end", {16'd0, dst_data}, {16'd0, 16'(base + len - 16'd1)});
        check("queues_drained", exp_load_q.size() + exp_wr_q.size(), 0);
      end
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin : main
    logic [23:0] s;
    logic [15:0] d;
    logic [15:0] l;
    int t0;
    int t_up;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_src_addr", {8'd0, src_addr}, 32'h0);
    check("rst_dst_addr", {16'd0, dst_addr}, 32'h0);
    check("rst_strobes", {30'd0, load_rom, dst_write}, 32'h0);
    check("rst_dst_data", {16'd0, dst_data}, 32'h0);
    check("rst_proc_en", {31'd0, proc_en}, 32'd1);
    check("rst_status", {16'd0, status}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // directed copy, ready four cycles after each load
    rom_delay_fixed = 4;
    do_xfer(24'h120100, 16'h0200, 16'd3, 16'hA000, 1'b0);
    rom_delay_fixed = 0;

    // zero-length start
    do_xfer(24'($urandom), 16'($urandom), 16'd0, 16'($urandom), 1'b0);

    // address wrap on both sides
    do_xfer(24'hFFFFFE, 16'hFFFF, 16'd2, 16'($urandom), 1'b0);

    // ready level held high throughout
    rom_mode = 1;
    ready = 1'b1;
    do_xfer(24'($urandom), 16'($urandom), 16'd4, 16'($urandom), 1'b0);
    rom_mode = 0;

    // randomised transfers, some with ignored writes while busy
    for (int n = 0; n < 8; n++) begin
      l = 16'($urandom_range(1, 6));
      do_xfer(24'($urandom), 16'($urandom), l, 16'($urandom), (l >= 16'd3) && ($urandom_range(0, 1) == 1));
    end

    // flash never answers: abort with error
    rom_mode = 2;
    ready = 1'b0;
    s = 24'($urandom);
    d = 16'($urandom);
    exp_load_q.push_back(s);
    n_wr_seen = 0;
    program_regs(s, d);
    reg_write(2'd3, 16'd3);
    check("to_start_proc_en", {31'd0, proc_en}, 32'd0);
    t0 = cyc;
    t_up = -1;
    for (int k = 0; k < TO + 20 && t_up < 0; k++) begin
      @(negedge clk);
      if (proc_en) t_up = cyc;
    end
    if (t_up < 0) begin
      fail("to_no_abort", {16'd0, status});
    end else begin
      check("to_cycles", t_up - t0, TO + 1);
      check("to_status", {16'd0, status}, 32'h0000_4000);
      check("to_src_kept", {8'd0, src_addr}, {8'd0, s});
      check("to_dst_kept", {16'd0, dst_addr}, {16'd0, d});
      check("to_no_write", n_wr_seen, 0);
    end
    reg_write(2'd3, 16'd0);
    check("err_cleared", {16'd0, status}, 32'h0);
    check("err_clear_proc_en", {31'd0, proc_en}, 32'd1);
    rom_mode = 0;

    // reset during WAIT of a five-word transfer
    rom_delay_fixed = 6;
    sb_en = 1'b0;
    program_regs(24'($urandom), 16'($urandom));
    reg_write(2'd3, 16'd5);
    repeat (2) @(negedge clk);
    check("pre_reset_busy", {15'd0, proc_en, status}, 32'h0000_8000);
    #2 rst = 1'b0;
    #1;
    check("arst_src_addr", {8'd0, src_addr}, 32'h0);
    check("arst_dst_addr", {16'd0, dst_addr}, 32'h0);
    check("arst_strobes", {30'd0, load_rom, dst_write}, 32'h0);
    check("arst_dst_data", {16'd0, dst_data}, 32'h0);
    check("arst_proc_en", {31'd0, proc_en}, 32'd1);
    check("arst_status", {16'd0, status}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    exp_load_q.delete();
    exp_wr_q.delete();
    gap_q.delete();
    rom_delay_fixed = 0;
    sb_en = 1'b1;
    d = 16'($urandom);
    reg_write(2'd2, d);
    check("post_reset_write", {16'd0, dst_addr}, {16'd0, d});

    // one more transfer after reset
    do_xfer(24'($urandom), 16'($urandom), 16'd3, 16'($urandom), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
